// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM round-robin arbiter.
package ram_arb_pkg;

  // Legal range for the requester count.
  localparam int unsigned MIN_REQ = 2;
  localparam int unsigned MAX_REQ = 8;

  // Lock state, used only when RAM_ARB_LOCK_EN is defined.
  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant_pick.sv
// Rotating-priority pick: one-hot grant to the first valid requester at or above i_ptr,
// wrapping modulo NUM_REQ.
module rr_grant_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_pick;

  // Rotate so i_ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    rot      = NUM_REQ'({i_valid, i_valid} >> i_ptr);
    rot_pick = rot & (~rot + NUM_REQ'(1));
    o_grant  = NUM_REQ'(({rot_pick, rot_pick} << i_ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter feeding one port of a registered-output RAM.
// Pipeline: accept -> S1 (RAM command registered) -> S2 (response strobe, RAM data).
// Optional owner lock enabled by defining RAM_ARB_LOCK_EN.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            i_req_lock,
`endif
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr,
  output logic [DATA_WIDTH-1:0]         o_ram_data,
  output logic                          o_ram_wr,
  input  logic [DATA_WIDTH-1:0]         i_ram_rdata
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    pick_grant, grant;
  logic [PtrW-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_wr;
  logic                  accept;

  // S1/S2 carry a one-hot tag; an all-zero tag means the stage is empty.
  logic [NUM_REQ-1:0]    s1_tag_q, s1_tag_d;
  logic [NUM_REQ-1:0]    s2_tag_q, s2_tag_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_wr_q, ram_wr_d;

  rr_grant_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (pick_grant)
  );

`ifdef RAM_ARB_LOCK_EN
  arb_state_e         state_q, state_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] owner_oh;

  // While locked only the owner may be granted.
  always_comb begin
    owner_oh = NUM_REQ'(1) << owner_q;
    grant    = (state_q == ARB_LOCKED) ? (i_req_valid & owner_oh) : pick_grant;
  end
`else
  // Plain round-robin grant.
  always_comb begin
    grant = pick_grant;
  end
`endif

  // Grant is forced off during reset; mux the granted requester's command.
  always_comb begin
    o_req_ready = i_rst ? '0 : grant;
    accept      = |o_req_ready;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_data    = '0;
    sel_wr      = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant[n]) begin
        grant_idx = PtrW'(n);
        sel_addr  = i_req_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = i_req_data[n*DATA_WIDTH +: DATA_WIDTH];
        sel_wr    = i_req_wr[n];
      end
    end
  end

  // Pointer and lock next-state.
  always_comb begin
    ptr_d = ptr_q;
`ifdef RAM_ARB_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          ptr_d = PtrW'(wrap_inc(int'(grant_idx), NUM_REQ));
          if (|(o_req_ready & i_req_lock)) begin
            state_d = ARB_LOCKED;
            owner_d = grant_idx;
          end
        end
      end
      ARB_LOCKED: begin
        // Release on an unlocked owner accept or when the owner drops valid.
        if (!(|(i_req_valid & owner_oh)) || (accept && !(|(i_req_lock & owner_oh)))) begin
          state_d = ARB_IDLE;
          ptr_d   = PtrW'(wrap_inc(int'(owner_q), NUM_REQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
`else
    if (accept) ptr_d = PtrW'(wrap_inc(int'(grant_idx), NUM_REQ));
`endif
  end

  // Pipeline next-state: address/data hold when S1 is empty, write enable does not.
  always_comb begin
    s1_tag_d   = o_req_ready;
    s2_tag_d   = s1_tag_q;
    ram_wr_d   = accept & sel_wr;
    ram_addr_d = accept ? sel_addr : ram_addr_q;
    ram_data_d = accept ? sel_data : ram_data_q;
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  // Lock state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`endif

  // Outputs: RAM command from S1, response from S2 with RAM data passed through.
  always_comb begin
    o_ram_addr  = ram_addr_q;
    o_ram_data  = ram_data_q;
    o_ram_wr    = ram_wr_q;
    o_rsp_valid = s2_tag_q;
    o_rsp_data  = (|s2_tag_q) ? i_ram_rdata : '0;
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed and scoreboarded bench for ram_rr_arbiter (4 requesters, 8-bit data, 3-bit addr).
module tb_ram_rr_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    valid, wr;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]    ready, rsp_valid;
  logic [DW-1:0]    rsp_data, ram_data, ram_rdata;
  logic [AW-1:0]    ram_addr;
  logic             ram_wr;
`ifdef RAM_ARB_LOCK_EN
  logic [NR-1:0]    lock = '0;
`endif

  logic [DW-1:0] mem [2**AW];
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [NR-1:0] tag;
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  ram_rr_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_wr    (wr),
    .i_req_addr  (addr),
    .i_req_data  (data),
`ifdef RAM_ARB_LOCK_EN
    .i_req_lock  (lock),
`endif
    .o_req_ready (ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_ram_addr  (ram_addr),
    .o_ram_data  (ram_data),
    .o_ram_wr    (ram_wr),
    .i_ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered-output RAM with write-through.
  always @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_addr] <= ram_data;
      ram_rdata     <= ram_data;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = '0;
    wr    = '0;
    addr  = '0;
    data  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    valid = 4'b1111;
    rst   = 1'b1;
    #1;
    vectors++;
    if (ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0000", ready);
    end
    vectors++;
    if (ram_wr !== 1'b0) begin
      miscompares++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr);
    end
    vectors++;
    if (ram_addr !== 3'd0 || ram_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_ram_cmd: got %h/%h want 0/00", ram_addr, ram_data);
    end
    tick();
    tick();
    vectors++;
    if (rsp_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 4'b0001) begin
      miscompares++; $display("FAIL reset_ptr0_grant: got %b want 0001", ready);
    end
    valid = '0;
  endtask

  // Only requester 3 valid with ptr = 0: granted every cycle.
  task automatic test_single_requester();
    clear_inputs();
    valid = 4'b1000;
    addr[3*AW +: AW] = 3'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (ready !== 4'b1000) begin
        miscompares++; $display("FAIL single_grant[%0d]: got %b want 1000", k, ready);
      end
      tick();
    end
    valid = '0;
    vectors++;
    if (rsp_valid !== 4'b1000) begin
      miscompares++; $display("FAIL single_rsp: got %b want 1000", rsp_valid);
    end
    tick();
    tick();
  endtask

  // All valid for 8 cycles: grants 0,1,2,3,0,1,2,3, responses two edges later.
  task automatic test_rotate();
    logic [NR-1:0] exp_g, exp_r;
    clear_inputs();
    valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      exp_r = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
      vectors++;
      if (ready !== exp_g) begin
        miscompares++; $display("FAIL rotate_grant[%0d]: got %b want %b", k, ready, exp_g);
      end
      vectors++;
      if (rsp_valid !== exp_r) begin
        miscompares++; $display("FAIL rotate_rsp[%0d]: got %b want %b", k, rsp_valid, exp_r);
      end
      tick();
    end
    valid = '0;
    tick();
    tick();
    vectors++;
    if (rsp_valid !== 4'b0000) begin
      miscompares++; $display("FAIL rotate_drain: got %b want 0000", rsp_valid);
    end
  endtask

  // req1 writes A5 to 5, req2 reads 5 the next cycle; both respond with A5.
  task automatic test_read_after_write();
    clear_inputs();
    valid = 4'b0010;
    wr    = 4'b0010;
    addr[1*AW +: AW] = 3'd5;
    data[1*DW +: DW] = 8'hA5;
    #1;
    vectors++;
    if (ready !== 4'b0010) begin
      miscompares++; $display("FAIL raw_grant_wr: got %b want 0010", ready);
    end
    tick();
    clear_inputs();
    valid = 4'b0100;
    addr[2*AW +: AW] = 3'd5;
    data[2*DW +: DW] = 8'h11;
    #1;
    vectors++;
    if (ready !== 4'b0100) begin
      miscompares++; $display("FAIL raw_grant_rd: got %b want 0100", ready);
    end
    vectors++;
    if (ram_wr !== 1'b1 || ram_addr !== 3'd5 || ram_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL raw_s1_write: got wr=%b a=%h d=%h want 1/5/a5", ram_wr, ram_addr, ram_data);
    end
    tick();
    clear_inputs();
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 8'hA5) begin
      miscompares++; $display("FAIL raw_rsp_wr: got %b/%h want 0010/a5", rsp_valid, rsp_data);
    end
    vectors++;
    if (ram_wr !== 1'b0 || ram_addr !== 3'd5) begin
      miscompares++; $display("FAIL raw_s1_read: got wr=%b a=%h want 0/5", ram_wr, ram_addr);
    end
    tick();
    vectors++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'hA5) begin
      miscompares++; $display("FAIL raw_rsp_rd: got %b/%h want 0100/a5", rsp_valid, rsp_data);
    end
    tick();
    vectors++;
    if (ram_addr !== 3'd5 || ram_wr !== 1'b0 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL raw_idle: got a=%h wr=%b rsp=%b want 5/0/0000", ram_addr, ram_wr, rsp_valid);
    end
  endtask

  // Reset one cycle after an accept: in-flight write dropped, no response, ptr back to 0.
  task automatic test_reset_midflight();
    clear_inputs();
    valid = 4'b0001;
    wr    = 4'b0001;
    addr[0 +: AW] = 3'd2;
    data[0 +: DW] = 8'h3C;
    #1;
    vectors++;
    if (ready !== 4'b0001) begin
      miscompares++; $display("FAIL midrst_grant: got %b want 0001", ready);
    end
    tick();
    vectors++;
    if (ram_wr !== 1'b1) begin
      miscompares++; $display("FAIL midrst_s1: got %b want 1", ram_wr);
    end
    clear_inputs();
    valid = 4'b1111;
    rst   = 1'b1;
    #1;
    vectors++;
    if (ram_wr !== 1'b0 || ram_addr !== 3'd0 || ram_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_async: got wr=%b a=%h d=%h want 0/0/00", ram_wr, ram_addr, ram_data);
    end
    vectors++;
    if (ready !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_ready: got %b want 0000", ready);
    end
    tick();
    vectors++;
    if (rsp_valid !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_no_rsp: got %b want 0000", rsp_valid);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 4'b0001) begin
      miscompares++; $display("FAIL midrst_ptr: got %b want 0001", ready);
    end
    tick();
    valid = '0;
    tick();
    vectors++;
    if (rsp_valid !== 4'b0001) begin
      miscompares++; $display("FAIL midrst_first_accept: got %b want 0001", rsp_valid);
    end
    vectors++;
    if (mem[2] === 8'h3C) begin
      miscompares++; $display("FAIL midrst_write_dropped: got %h want not 3c", mem[2]);
    end
    tick();
  endtask

`ifdef RAM_ARB_LOCK_EN
  // req0 locks while all others are valid; only req0 granted until it unlocks.
  task automatic test_lock();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    valid = 4'b1111;
    lock  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (ready !== 4'b0001) begin
        miscompares++; $display("FAIL lock_grant[%0d]: got %b want 0001", k, ready);
      end
      tick();
    end
    lock = 4'b0000;
    #1;
    vectors++;
    if (ready !== 4'b0001) begin
      miscompares++; $display("FAIL lock_release_grant: got %b want 0001", ready);
    end
    tick();
    vectors++;
    if (ready !== 4'b0010) begin
      miscompares++; $display("FAIL lock_after_release: got %b want 0010", ready);
    end
    valid = '0;
    tick();
    tick();
  endtask
`endif

  // Random traffic against a round-robin model, shadow memory and in-order response queue.
  task automatic test_random();
    rsp_t          q[$];
    rsp_t          r;
    logic [DW-1:0] shadow [2**AW];
    logic [NR-1:0] exp_g;
    int            waits [NR];
    int            mptr;
    int            gi;
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2**AW; i++) shadow[i] = mem[i];
    for (int i = 0; i < NR; i++) waits[i] = 0;
    mptr = 0;
    c    = 0;
    for (int cyc = 0; cyc < 10002; cyc++) begin
      if (cyc < 10000) begin
        valid = 4'($urandom_range(0, 15));
        wr    = 4'($urandom);
        addr  = 12'($urandom);
        data  = 32'($urandom);
      end else begin
        clear_inputs();
      end
      #1;
      exp_g = '0;
      gi    = 0;
      for (int i = 0; i < NR; i++) begin
        int idx;
        idx = (mptr + i) % NR;
        if (exp_g == '0 && valid[idx]) begin
          exp_g[idx] = 1'b1;
          gi         = idx;
        end
      end
      vectors++;
      if (ready !== exp_g) begin
        miscompares++; $display("FAIL rand_grant@%0d: got %b want %b", cyc, ready, exp_g);
      end
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        vectors++;
        if (rsp_valid !== r.tag || rsp_data !== r.d) begin
          miscompares++;
          $display("FAIL rand_rsp@%0d: got %b/%h want %b/%h", cyc, rsp_valid, rsp_data, r.tag, r.d);
        end
      end else begin
        vectors++;
        if (rsp_valid !== '0) begin
          miscompares++; $display("FAIL rand_spurious_rsp@%0d: got %b want 0000", cyc, rsp_valid);
        end
      end
      for (int n = 0; n < NR; n++) begin
        if (!valid[n] || exp_g[n]) begin
          waits[n] = 0;
        end else if (exp_g != '0) begin
          waits[n]++;
          vectors++;
          if (waits[n] > NR - 1) begin
            miscompares++; $display("FAIL rand_starve[%0d]: got %0d waits want <= %0d", n, waits[n], NR - 1);
          end
        end
      end
      if (exp_g != '0) begin
        a = addr[gi*AW +: AW];
        if (wr[gi]) begin
          e         = data[gi*DW +: DW];
          shadow[a] = e;
        end else begin
          e = shadow[a];
        end
        q.push_back('{tag: exp_g, d: e, due: c + 2});
        mptr = (gi + 1) % NR;
      end
      tick();
      c++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL rand_leftover: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    ram_rdata = '0;
    clear_inputs();
    test_reset();
    test_single_requester();
    test_rotate();
    test_read_after_write();
    test_reset_midflight();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: RAM address width.
REQ-003 SHALL have parameter NUM_REQ, default 4: requester count, range 2..8.
REQ-004 SHALL have one clock and an asynchronous active-high reset:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have these requester ports:
- i_req_valid  in  NUM_REQ  per-requester command valid.
- i_req_wr  in  NUM_REQ  1 = write, 0 = read.
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- o_req_ready  out  NUM_REQ  one-hot grant/accept.
- o_rsp_valid  out  NUM_REQ  one-hot response strobe.
- o_rsp_data  out  DATA_WIDTH  response data, shared.
REQ-006 SHALL have these RAM-port ports, driving one port of the registered-output dual-port RAM:
- o_ram_addr  out  ADDR_WIDTH  address.
- o_ram_data  out  DATA_WIDTH  write data.
- o_ram_wr  out  1  write enable.
- i_ram_rdata  in  DATA_WIDTH  RAM registered output.

Function
REQ-007 SHALL accept at most one command per cycle; a command is accepted at a rising edge where i_req_valid[n] & o_req_ready[n].
REQ-008 SHALL drive o_req_ready combinationally, as at most one bit, to the first valid requester found searching from pointer ptr upward modulo NUM_REQ.
REQ-009 SHALL hold o_req_ready all-zero when no requester is valid.
REQ-010 SHALL set ptr to (granted index + 1) mod NUM_REQ on each accept, and hold ptr otherwise.
REQ-011 SHALL register the accepted addr/data/wr onto o_ram_addr/o_ram_data/o_ram_wr in the cycle following the accept (stage S1).
REQ-012 SHALL drive o_ram_wr = 0 in any cycle with no S1 command; o_ram_addr and o_ram_data hold their last value.
REQ-013 SHALL carry a one-hot tag through S1 and S2, and assert o_rsp_valid[tag] in S2, exactly 2 edges after the accept.
REQ-014 SHALL drive o_rsp_data = i_ram_rdata (passthrough) while o_rsp_valid is nonzero.
REQ-015 SHALL produce responses for writes too, with o_rsp_data equal to the written word (RAM write-through).
REQ-016 SHALL sustain back-to-back accepts at full throughput, responses in accept order.
REQ-017 SHALL give a read to address A, accepted one cycle after a write to A, the new data.
REQ-018 SHALL ignore inputs of requesters that do not hold a grant.

Reset
REQ-019 SHALL, while i_rst = 1, force ptr = 0, S1/S2 valid = 0, o_ram_wr = 0, o_ram_addr = 0, o_ram_data = 0, o_rsp_valid = 0.
REQ-020 SHALL hold o_req_ready = 0 while i_rst = 1.
REQ-021 SHALL discard in-flight commands on reset mid-operation, producing no response for them.
REQ-022 SHALL allow the first accept at the first rising edge after i_rst deasserts.

Configuration
REQ-023 SHALL, with RAM_ARB_LOCK_EN defined, add input i_req_lock [NUM_REQ].
REQ-024 SHALL, with RAM_ARB_LOCK_EN defined, enter a LOCKED state owned by requester n when an accept has i_req_lock[n] = 1.
REQ-025 SHALL, in LOCKED, grant only the owner and not advance ptr.
REQ-026 SHALL leave LOCKED (back to IDLE, ptr = owner + 1) on an owner accept with lock = 0, or when the owner deasserts valid.
REQ-027 SHALL, with RAM_ARB_LOCK_EN undefined, have no i_req_lock port and no LOCKED state; behaviour is REQ-007..018 only.

Structure
REQ-028 SHALL place in package ram_arb_pkg: the lock state enum (ARB_IDLE, ARB_LOCKED) and the NUM_REQ bound constants MIN_REQ = 2 and MAX_REQ = 8.
REQ-029 SHALL implement the rotating priority search in one combinational sub-module, rr_grant_pick (inputs: valid vector, ptr; output: one-hot grant).

Verification
REQ-030 SHALL cover: reset, then valid = 4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3, ptr wraps 3 -> 0.
REQ-031 SHALL cover: req1 writes 0xA5 to addr 5, req2 reads addr 5 the next cycle -> o_rsp_valid = 4'b0010 with data 0xA5, then 4'b0100 with data 0xA5, 2 edges after each accept.
REQ-032 SHALL cover: only req3 valid, ptr = 0 -> grant 4'b1000 immediately, no idle gaps.
REQ-033 SHALL cover: i_rst asserted 1 cycle after an accept -> no o_rsp_valid, o_ram_wr = 0 asynchronously, ptr = 0.
REQ-034 SHALL cover, with RAM_ARB_LOCK_EN: req0 locks, req1..3 valid for 4 cycles -> only req0 granted; req0 unlocks -> next grant is req1.
REQ-035 SHALL cover: random traffic for 10k cycles against a scoreboard -> every accept gets exactly one in-order response, no requester starved more than NUM_REQ-1 accepts.
